// File: rtl/antichain_pkg.sv
// Shared constants, FSM state type and priority-encoder helper for the antichain
// extraction path.
package antichain_pkg;

  localparam int unsigned N_VARS = 7;
  localparam int unsigned FUNC_W = 128;
  localparam int unsigned IDX_W  = 7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StEmit = 2'd2
  } state_e;

  // Index of the lowest set bit; an all-zero vector maps to 0.
  function automatic logic [IDX_W-1:0] lowest_set_index(input logic [FUNC_W-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = FUNC_W - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/antichain_mask.sv
// Combinational minimal-element mask of a 7-variable Boolean function, plus a flag
// raised when the function is not upward-closed.
module antichain_mask
  import antichain_pkg::*;
(
  input  logic [FUNC_W-1:0] i_func,
  output logic [FUNC_W-1:0] o_mask,
  output logic              o_not_monotone
);

  logic [IDX_W-1:0] w_nb;

  always_comb begin
    o_mask         = '0;
    o_not_monotone = 1'b0;
    w_nb           = '0;
    for (int i = 0; i < int'(FUNC_W); i++) begin
      o_mask[i] = i_func[i];
      for (int j = 0; j < int'(N_VARS); j++) begin
        w_nb = IDX_W'(i) ^ (IDX_W'(1) << j);
        if (IDX_W'(i) & (IDX_W'(1) << j)) begin
          // A set subset directly below i disqualifies i as minimal.
          o_mask[i] = o_mask[i] & ~i_func[w_nb];
        end else begin
          o_not_monotone = o_not_monotone | (i_func[i] & ~i_func[w_nb]);
        end
      end
    end
  end

endmodule

// File: rtl/antichain_extract.sv
// Accepts one monotone function, then streams its minimal elements lowest-first,
// one beat per accepted handshake.
module antichain_extract
  import antichain_pkg::*;
#(
  parameter int unsigned N_VARS = 7,
  parameter int unsigned FUNC_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FUNC_W-1:0] in_func,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_VARS-1:0] out_index,
  output logic              out_last,
  output logic              out_empty,
  output logic              out_not_monotone
);

  state_e            r_state;
  logic [FUNC_W-1:0] r_func;
  logic [FUNC_W-1:0] r_remaining;
  logic              r_not_mono;

  logic [FUNC_W-1:0] w_mask;
  logic              w_not_mono;
  logic [FUNC_W-1:0] w_rem_cleared;
  logic              w_single;

  antichain_mask u_mask (
    .i_func         (r_func),
    .o_mask         (w_mask),
    .o_not_monotone (w_not_mono)
  );

  // Clearing the lowest set bit; an empty remainder stays empty.
  assign w_rem_cleared = r_remaining & (r_remaining - FUNC_W'(1));
  assign w_single      = (w_rem_cleared == '0);

  assign in_ready         = (r_state == StIdle);
  assign out_valid        = (r_state == StEmit);
  assign out_index        = lowest_set_index(r_remaining);
  assign out_last         = out_valid & w_single;
  assign out_empty        = out_valid & (r_remaining == '0);
  assign out_not_monotone = out_valid & r_not_mono;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_func      <= '0;
      r_remaining <= '0;
      r_not_mono  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_func  <= in_func;
            r_state <= StCalc;
          end
        end
        StCalc: begin
          r_remaining <= w_mask;
          r_not_mono  <= w_not_mono;
          r_state     <= StEmit;
        end
        StEmit: begin
          if (out_ready) begin
            r_remaining <= w_rem_cleared;
            if (w_single) r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_antichain_extract.sv
// Directed self-checking bench for antichain_extract.
module tb_antichain_extract;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_func;
  logic         out_valid;
  logic         out_ready;
  logic [6:0]   out_index;
  logic         out_last;
  logic         out_empty;
  logic         out_not_monotone;

  int n_checks;
  int n_errors;
  int exp_q[$];

  antichain_extract #(
    .N_VARS (7),
    .FUNC_W (128)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_func          (in_func),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_index        (out_index),
    .out_last         (out_last),
    .out_empty        (out_empty),
    .out_not_monotone (out_not_monotone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Upward closure of a set of generator subsets given as a bitmap.
  function automatic logic [127:0] closure(input logic [127:0] gens);
    logic [127:0] f;
    f = '0;
    for (int i = 0; i < 128; i++)
      for (int k = 0; k < 128; k++)
        if (gens[k] && ((i & k) == k)) f[i] = 1'b1;
    return f;
  endfunction

  // Wait for idle (bounded), present f for exactly one accepting edge.
  task automatic send(input string tag, input logic [127:0] f);
    int waited;
    waited = 0;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    chk({tag, "_in_ready_bound"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_func  = f;
    tick();
    in_valid = 1'b0;
    chk({tag, "_calc_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_calc_valid"}, 32'(out_valid), 32'd0);
  endtask

  // With out_ready high: one beat per cycle matching exp_q, then idle.
  task automatic drain(input string tag, input logic exp_empty, input logic exp_nm);
    tick();
    for (int k = 0; k < exp_q.size(); k++) begin
      chk($sformatf("%s_valid_%0d", tag, k), 32'(out_valid), 32'd1);
      chk($sformatf("%s_index_%0d", tag, k), 32'(out_index), 32'(exp_q[k]));
      chk($sformatf("%s_last_%0d", tag, k), 32'(out_last), 32'(k == exp_q.size() - 1));
      chk($sformatf("%s_empty_%0d", tag, k), 32'(out_empty), 32'(exp_empty));
      chk($sformatf("%s_nm_%0d", tag, k), 32'(out_not_monotone), 32'(exp_nm));
      chk($sformatf("%s_busy_%0d", tag, k), 32'(in_ready), 32'd0);
      tick();
    end
    chk({tag, "_done_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_done_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [127:0] gens;
    logic [127:0] f;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_func   = '0;
    out_ready = 1'b1;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_empty", 32'(out_empty), 32'd0);
    chk("rst_out_nm", 32'(out_not_monotone), 32'd0);
    chk("rst_out_index", 32'(out_index), 32'd0);
    rst_n = 1'b1;
    tick();

    // All-zero function: a single empty beat.
    exp_q = {0};
    send("zero", '0);
    drain("zero", 1'b1, 1'b0);

    // All-ones: only the empty subset is minimal.
    exp_q = {0};
    send("ones", {128{1'b1}});
    drain("ones", 1'b0, 1'b0);

    // Closure of {3, 4}.
    gens = '0;
    gens[3] = 1'b1;
    gens[4] = 1'b1;
    exp_q = {3, 4};
    send("c34", closure(gens));
    drain("c34", 1'b0, 1'b0);

    // Weight >= 3 layer: 35 beats from 7 to 112.
    f = '0;
    exp_q.delete();
    for (int i = 0; i < 128; i++) begin
      if ($countones(i) >= 3) f[i] = 1'b1;
      if ($countones(i) == 3) exp_q.push_back(i);
    end
    chk("w3_count", 32'(exp_q.size()), 32'd35);
    send("w3", f);
    drain("w3", 1'b0, 1'b0);

    // Lone bit 5: not monotone, with a 5-cycle stall and ignored in_valid.
    out_ready = 1'b0;
    f = '0;
    f[5] = 1'b1;
    send("b5", f);
    tick();
    in_valid = 1'b1;
    in_func  = {128{1'b1}};
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("b5_stall_valid_%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("b5_stall_index_%0d", k), 32'(out_index), 32'd5);
      chk($sformatf("b5_stall_last_%0d", k), 32'(out_last), 32'd1);
      chk($sformatf("b5_stall_empty_%0d", k), 32'(out_empty), 32'd0);
      chk($sformatf("b5_stall_nm_%0d", k), 32'(out_not_monotone), 32'd1);
      chk($sformatf("b5_stall_in_ready_%0d", k), 32'(in_ready), 32'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("b5_final_index", 32'(out_index), 32'd5);
    tick();
    chk("b5_done_valid", 32'(out_valid), 32'd0);
    chk("b5_done_in_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of the {3, 4} stream.
    send("rst", closure(gens));
    tick();
    chk("rst_first_index", 32'(out_index), 32'd3);
    tick();
    chk("rst_second_index", 32'(out_index), 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_last", 32'(out_last), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_after_valid", 32'(out_valid), 32'd0);
    exp_q = {0};
    send("post", {128{1'b1}});
    drain("post", 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
